// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion bank controller: filters gate-array RAM-config port writes
// into mode/bank registers and decodes SRAM select/address. Optional macro: CFG_READBACK_EN.
module cpc_ram_bank_ctrl #(
    parameter int BANK_BITS     = 3,
    parameter int FILTER_CYCLES = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [15:0]            A,
    input  logic [7:0]             D_IN,
    input  logic                   IOREQ_B,
    input  logic                   WR_B,
    input  logic                   RD_B,
    input  logic                   MREQ_B,
    output logic [BANK_BITS+1:0]   RAM_ADR_HI,
    output logic                   RAM_CS_B,
    output logic                   RAMDIS,
    output logic [7:0]             D_OUT,
    output logic                   D_OE
);

    // state | meaning
    // IDLE  | waiting for a port write (only once the strobe has been seen released)
    // FILT  | counting consecutive hit edges towards FILTER_CYCLES
    // HOLD  | captured; waiting for the write strobe to end
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] FILT_N = 4'(FILTER_CYCLES);

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [2:0]             mode_q, mode_d;
    logic [BANK_BITS-1:0]   bank_q, bank_d;
    logic                   arm_q, arm_d;

    logic                   wr_hit;
    logic                   strobe_rel;
    logic [3:0]             cnt_inc;
    logic [BANK_BITS-1:0]   bank_src;
    logic                   ext_sel;
    logic [1:0]             ext_page;
    logic                   unused_bits;

    assign wr_hit     = !IOREQ_B && !WR_B && !A[15] && (D_IN[7:6] == 2'b11);
    assign strobe_rel = IOREQ_B | WR_B;
    assign cnt_inc    = {1'b0, cnt_q} + 4'd1;

    // Upper bank bits come from the inverted port address: &7F is group 0.
    always_comb begin
        bank_src      = '0;
        bank_src[2:0] = D_IN[5:3];
        for (int i = 3; i < BANK_BITS; i++) begin
            bank_src[i] = ~A[i + 5];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        bank_d  = bank_q;
        arm_d   = arm_q | strobe_rel;
        case (state_q)
            ST_IDLE: begin
                if (wr_hit && arm_q) begin
                    cnt_d = 3'd1;
                    if (FILT_N == 4'd1) begin
                        mode_d  = D_IN[2:0];
                        bank_d  = bank_src;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_FILT;
                    end
                end
            end
            ST_FILT: begin
                if (wr_hit) begin
                    cnt_d = cnt_inc[2:0];
                    if (cnt_inc == FILT_N) begin
                        mode_d  = D_IN[2:0];
                        bank_d  = bank_src;
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (strobe_rel) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A strobe still low when reset is released must not capture until it is re-issued.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            mode_q  <= 3'd0;
            bank_q  <= '0;
            arm_q   <= strobe_rel;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            bank_q  <= bank_d;
            arm_q   <= arm_d;
        end
    end

    always_comb begin
        ext_sel  = 1'b0;
        ext_page = 2'd0;
        case (mode_q)
            3'd0: ext_sel = 1'b0;
            3'd1, 3'd3: begin
                ext_sel  = (A[15:14] == 2'd3);
                ext_page = 2'd3;
            end
            3'd2: begin
                ext_sel  = 1'b1;
                ext_page = A[15:14];
            end
            default: begin
                ext_sel  = (A[15:14] == 2'd1);
                ext_page = mode_q[1:0];
            end
        endcase
        if (!ext_sel) begin
            ext_page = 2'd0;
        end
    end

    assign RAMDIS     = ext_sel;
    assign RAM_CS_B   = ~ext_sel | MREQ_B;
    assign RAM_ADR_HI = {bank_q, ext_page};

`ifdef CFG_READBACK_EN
    logic rd_hit;
    logic d_oe_q, d_oe_d;

    assign rd_hit = !IOREQ_B && !RD_B && !A[15] && A[14];

    always_comb begin
        d_oe_d = d_oe_q;
        if (d_oe_q) begin
            d_oe_d = !(RD_B | IOREQ_B);
        end else begin
            d_oe_d = rd_hit;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            d_oe_q <= 1'b0;
        end else begin
            d_oe_q <= d_oe_d;
        end
    end

    assign D_OE  = d_oe_q;
    assign D_OUT = d_oe_q ? {2'b11, bank_q[2:0], mode_q} : 8'h00;
`else
    assign D_OE  = 1'b0;
    assign D_OUT = 8'h00;
`endif

    assign unused_bits = ^{A, RD_B};

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Bench for cpc_ram_bank_ctrl: two instances (512K/no filter, 4M/3-edge filter)
// on one bus, checked against a transaction-level model of the port and mapping.
module tb_cpc_ram_bank_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic        IOREQ_B, WR_B, RD_B, MREQ_B;

    logic [4:0]  a_adr;
    logic        a_cs, a_dis, a_oe;
    logic [7:0]  a_dout;
    logic [7:0]  b_adr;
    logic        b_cs, b_dis, b_oe;
    logic [7:0]  b_dout;

    int n_vec = 0;
    int n_err = 0;

    int fcyc [2] = '{1, 3};
    int bbits[2] = '{3, 6};
    int m_mode[2], m_bank[2], m_run[2], m_done[2], m_armed[2], m_oe[2];

    always #5 CLK = ~CLK;

    cpc_ram_bank_ctrl #(.BANK_BITS(3), .FILTER_CYCLES(1)) u_a (
        .CLK(CLK), .RESET(RESET), .A(A), .D_IN(D_IN),
        .IOREQ_B(IOREQ_B), .WR_B(WR_B), .RD_B(RD_B), .MREQ_B(MREQ_B),
        .RAM_ADR_HI(a_adr), .RAM_CS_B(a_cs), .RAMDIS(a_dis),
        .D_OUT(a_dout), .D_OE(a_oe)
    );

    cpc_ram_bank_ctrl #(.BANK_BITS(6), .FILTER_CYCLES(3)) u_b (
        .CLK(CLK), .RESET(RESET), .A(A), .D_IN(D_IN),
        .IOREQ_B(IOREQ_B), .WR_B(WR_B), .RD_B(RD_B), .MREQ_B(MREQ_B),
        .RAM_ADR_HI(b_adr), .RAM_CS_B(b_cs), .RAMDIS(b_dis),
        .D_OUT(b_dout), .D_OE(b_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void exp_map(input int mode, input int p, output int sel, output int page);
        sel  = 0;
        page = 0;
        if (mode == 1 || mode == 3) begin
            sel  = (p == 3) ? 1 : 0;
            page = 3;
        end else if (mode == 2) begin
            sel  = 1;
            page = p;
        end else if (mode >= 4) begin
            sel  = (p == 1) ? 1 : 0;
            page = mode - 4;
        end
        if (sel == 0) page = 0;
    endfunction

    // Called right after each rising edge with the inputs that were sampled there.
    task automatic mdl_edge();
        bit hit, strobe_low, rd_hit;
        hit        = !IOREQ_B && !WR_B && !A[15] && (D_IN[7:6] == 2'b11);
        strobe_low = !IOREQ_B && !WR_B;
        rd_hit     = !IOREQ_B && !RD_B && !A[15] && A[14];
        for (int k = 0; k < 2; k++) begin
            if (RESET) begin
                m_mode[k]  = 0;
                m_bank[k]  = 0;
                m_run[k]   = 0;
                m_done[k]  = 0;
                m_armed[k] = strobe_low ? 0 : 1;
                m_oe[k]    = 0;
            end else begin
                if (hit && m_armed[k] != 0 && m_done[k] == 0) begin
                    m_run[k]++;
                    if (m_run[k] == fcyc[k]) begin
                        m_mode[k] = int'(D_IN[2:0]);
                        m_bank[k] = int'(D_IN[5:3])
                                  | ((int'(~A[15:8]) & ((1 << (bbits[k] - 3)) - 1)) << 3);
                        m_done[k] = 1;
                        m_run[k]  = 0;
                    end
                end else if (!hit) begin
                    m_run[k] = 0;
                end
                if (!strobe_low) begin
                    m_done[k]  = 0;
                    m_armed[k] = 1;
                end
                if (m_oe[k] != 0) m_oe[k] = (!RD_B && !IOREQ_B) ? 1 : 0;
                else              m_oe[k] = rd_hit ? 1 : 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int sel, page, e_adr, e_cs, e_oe, e_do;
        logic [31:0] o_adr, o_cs, o_dis, o_oe, o_do;
        for (int k = 0; k < 2; k++) begin
            exp_map(m_mode[k], int'(A[15:14]), sel, page);
            e_adr = (m_bank[k] << 2) | page;
            e_cs  = (sel == 0 || MREQ_B) ? 1 : 0;
`ifdef CFG_READBACK_EN
            e_oe = m_oe[k];
            e_do = (m_oe[k] != 0) ? (8'hC0 | ((m_bank[k] & 7) << 3) | m_mode[k]) : 0;
`else
            e_oe = 0;
            e_do = 0;
`endif
            o_adr = (k == 0) ? 32'(a_adr)  : 32'(b_adr);
            o_cs  = (k == 0) ? 32'(a_cs)   : 32'(b_cs);
            o_dis = (k == 0) ? 32'(a_dis)  : 32'(b_dis);
            o_oe  = (k == 0) ? 32'(a_oe)   : 32'(b_oe);
            o_do  = (k == 0) ? 32'(a_dout) : 32'(b_dout);
            chk($sformatf("%s_u%0d_adr", tag, k), o_adr, e_adr);
            chk($sformatf("%s_u%0d_cs",  tag, k), o_cs,  e_cs);
            chk($sformatf("%s_u%0d_dis", tag, k), o_dis, sel);
            chk($sformatf("%s_u%0d_oe",  tag, k), o_oe,  e_oe);
            chk($sformatf("%s_u%0d_dout",tag, k), o_do,  e_do);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        mdl_edge();
        @(negedge CLK);
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d,
                       input logic io, input logic wr, input logic rd, input logic mr);
        A = a; D_IN = d; IOREQ_B = io; WR_B = wr; RD_B = rd; MREQ_B = mr;
    endtask

    int hold_left;
    int op;

    initial begin
        RESET = 1'b1;
        bus(16'hC000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);

        // reset with a mapped-looking access on the bus
        tick(); tick();
        #1;
        chk("rst_a_dis", a_dis, 1'b0);
        chk("rst_a_cs",  a_cs,  1'b1);
        chk("rst_a_adr", a_adr, 5'd0);
        chk("rst_b_adr", b_adr, 8'd0);
        chk("rst_b_oe",  b_oe,  1'b0);
        check_all("rst");
        RESET = 1'b0;

        // mode 2 write, single edge
        bus(16'h7F00, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        bus(16'h8000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("m2_a_cs",  a_cs,  1'b0);
        chk("m2_a_dis", a_dis, 1'b1);
        chk("m2_a_adr", a_adr, 5'b00010);
        chk("m2_b_dis", b_dis, 1'b0);
        check_all("m2");
        tick();

        // wide bank, mode 5, port &7E
        bus(16'h7E00, 8'hC5, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick();
        bus(16'h4000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("wide_b_adr", b_adr, 8'h21);
        chk("wide_b_cs",  b_cs,  1'b0);
        chk("wide_a_adr", a_adr, 5'h01);
        check_all("wide4k");
        A = 16'h0000;
        #1;
        chk("wide_b_cs0",  b_cs,  1'b1);
        chk("wide_b_dis0", b_dis, 1'b0);
        check_all("wide0k");
        tick();

        // short hit rejected by the 3-edge filter
        bus(16'h7F00, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        bus(16'h4000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("filt_rej_b_adr", b_adr, 8'h21);
        check_all("filt_rej");
        tick();

        // long hit: data changes after capture must not be taken
        bus(16'h7F00, 8'hC6, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick();
        D_IN = 8'hC1;
        for (int i = 0; i < 7; i++) tick();
        bus(16'h4000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("long_b_adr", b_adr, 8'h02);
        chk("long_b_dis", b_dis, 1'b1);
        chk("long_a_adr", a_adr, 5'h02);
        check_all("long");
        tick();

        // reset in the middle of a filtered write, strobe kept low
        bus(16'h7F00, 8'hC7, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("rstw_b_dis", b_dis, 1'b0);
        chk("rstw_a_dis", a_dis, 1'b0);
        chk("rstw_b_adr", b_adr, 8'h00);
        check_all("rstw");
        IOREQ_B = 1'b1; WR_B = 1'b1;
        tick();
        IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(); tick(); tick();
        IOREQ_B = 1'b1; WR_B = 1'b1;
        #1;
        chk("rearm_b_dis", b_dis, 1'b1);
        chk("rearm_b_adr", b_adr, 8'h03);
        chk("rearm_a_adr", a_adr, 5'h03);
        check_all("rearm");
        tick();

        // readback of the configuration register
        bus(16'h7F00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("rb_pre_oe", a_oe, 1'b0);
        tick();
        #1;
`ifdef CFG_READBACK_EN
        chk("rb_a_oe",   a_oe,   1'b1);
        chk("rb_a_dout", a_dout, 8'hC7);
`else
        chk("rb_a_oe",   a_oe,   1'b0);
        chk("rb_a_dout", a_dout, 8'h00);
`endif
        check_all("rb");
        RD_B = 1'b1;
        #1;
        check_all("rb_hold");
        tick();
        #1;
        chk("rb_off_oe", a_oe, 1'b0);
        check_all("rb_off");

        // randomized bus traffic
        hold_left = 0;
        for (int c = 0; c < 3000; c++) begin
            RESET = ($urandom_range(0, 199) == 0);
            if (hold_left == 0) begin
                hold_left = $urandom_range(1, 6);
                op = $urandom_range(0, 3);
                case (op)
                    0: bus(16'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, 1'($urandom));
                    1: bus({($urandom_range(0, 3) == 0), 4'b1111, 3'($urandom), 8'($urandom)},
                           ($urandom_range(0, 3) != 0) ? {2'b11, 6'($urandom)} : 8'($urandom),
                           1'b0, 1'b0, 1'b1, 1'b1);
                    2: bus({($urandom_range(0, 3) == 0), 15'($urandom)}, 8'($urandom),
                           1'b0, 1'b1, 1'b0, 1'b1);
                    default: bus(16'($urandom), 8'($urandom), 1'b1,
                                 1'($urandom), 1'($urandom), 1'b0);
                endcase
            end else begin
                hold_left--;
                if ($urandom_range(0, 7) == 0) D_IN = 8'($urandom);
            end
            #1;
            check_all("rnd");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpc_ram_bank_ctrl.md
# cpc_ram_bank_ctrl

Synchronous, parametrised successor to the discrete-logic CPC RAM expansion decoder. It snoops Z80 I/O writes to the gate-array RAM configuration port and filters them into a registered mapping mode and bank register. It decodes every memory access into the external SRAM chip-select, the RAMDIS override and the SRAM high address bits. The bank register is scalable from 512K (8 × 64K banks) to 4M (64 banks), and the block sits between the CPC edge connector and the SRAM on the expansion board's CPLD.

## Interface
Parameters:
- BANK_BITS, 3, width of the 64K bank number; legal range 3..6 (512K..4M).
- FILTER_CYCLES, 1, number of consecutive CLK samples of a valid port write required before capture; legal range 1..7.

Ports:
- CLK  in  1  CPC 4 MHz bus clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- A  in  16  Z80 address bus.
- D_IN  in  8  Z80 data bus, input view.
- IOREQ_B, WR_B, RD_B, MREQ_B  in  1 each  Z80 strobes, active low.
- RAM_ADR_HI  out  BANK_BITS+2  SRAM address bits above A13, ordered {bank, ext_page}.
- RAM_CS_B  out  1  SRAM chip select, active low.
- RAMDIS  out  1  disables CPC internal RAM, active high.
- D_OUT  out  8  configuration readback data.
- D_OE  out  1  D_OUT drive enable.

## Operation
- Port hit (combinational): IOREQ_B=0, WR_B=0, A15=0, D_IN[7:6]=11.
- Bank source:
  - bank[2:0] = D_IN[5:3].
  - bank[BANK_BITS-1:3] = ~A[8+BANK_BITS-4 : 8]. Port &7F gives group 0, &7E group 1, and so on down to &78.
- Mode source: mode[2:0] = D_IN[2:0].
- Write FSM states:
  - IDLE: if hit, cnt←1. If FILTER_CYCLES=1, capture mode and bank on this edge and go to HOLD; otherwise go to FILT.
  - FILT: if hit, cnt←cnt+1; when cnt+1 = FILTER_CYCLES, capture and go to HOLD. If hit is lost, return to IDLE with no update.
  - HOLD: stay until IOREQ_B=1 or WR_B=1, then go to IDLE.
- Exactly one capture per I/O write cycle, however long the strobe is held.
- Mapping, combinational from the registered mode and A15:A14, with p = A15:A14:
  - Mode 0: ext_sel=0.
  - Mode 1 or 3: ext_sel = (p=3), ext_page=3.
  - Mode 2: ext_sel=1, ext_page=p.
  - Modes 4..7: ext_sel = (p=1), ext_page = mode-4.
  - When ext_sel=0, ext_page=0.
- RAMDIS = ext_sel, independent of MREQ_B.
- RAM_CS_B = ~ext_sel | MREQ_B.
- RAM_ADR_HI = {bank, ext_page}.
- Reset: FSM→IDLE, cnt=0, mode=0, bank=0, D_OE=0. This forces RAMDIS=0, RAM_CS_B=1, RAM_ADR_HI=0 and D_OUT=0 regardless of the bus.
- Reset during FILT or HOLD discards any in-flight write. A write strobe still held low after reset is released does not capture until it is deasserted and reasserted.

## Timing
- Capture happens on the FILTER_CYCLES-th consecutive rising edge at which hit is sampled high. Mapping outputs reflect the new mode and bank immediately after that edge.
- Mapping outputs are combinational from registers and A/MREQ_B, with no added cycle latency on memory accesses.
- A hit sampled while in HOLD is ignored.
- A hit that deasserts and reasserts within a single CLK period is treated as continuous, because it is sampled only on edges.
- D_OE asserts on the edge after a readback hit is first sampled, and deasserts on the edge after RD_B=1 or IOREQ_B=1.

## Configuration
- CFG_READBACK_EN defined:
  - Readback hit = IOREQ_B=0, RD_B=0, A15=0, A14=1.
  - D_OE is registered as described under Timing.
  - D_OUT = {2'b11, bank[2:0], mode[2:0]}.
- CFG_READBACK_EN undefined: D_OUT=8'h00 and D_OE=0 constantly; RD_B is unused. Ports are present in both builds.

## Test plan
- Reset check: assert RESET for 2 cycles with A=16'hC000, MREQ_B=0 -> RAMDIS=0, RAM_CS_B=1, RAM_ADR_HI=0.
- Mode 2 mapping: write A=16'h7F00, D_IN=8'hC2, FILTER_CYCLES=1, BANK_BITS=3 -> capture on the first edge. Then A=16'h8000, MREQ_B=0 -> RAM_CS_B=0, RAMDIS=1, RAM_ADR_HI=5'b00010.
- Wide bank, mode 5: BANK_BITS=6, write A=16'h7E00, D_IN=8'hC5 -> bank=6'b001000. Then A=16'h4000 -> RAM_ADR_HI=8'h21. A=16'h0000 -> RAM_CS_B=1, RAMDIS=0.
- Filter rejection and hold:
  - FILTER_CYCLES=3, a hit held for 2 edges -> no change.
  - A hit held for 10 edges, with D_IN changed to 8'hC1 after capture -> the captured value is the edge-3 data, and only one capture occurs.
- Reset during write: with a hit held, assert RESET during FILT, release it with the strobe still low -> mode=0 and no capture until the strobe is released and reasserted.
- Readback, built with CFG_READBACK_EN, after writing 8'hC7:
  - Read A=16'h7F00 -> D_OE=1 one edge later, D_OUT=8'hC7.
  - Raise RD_B -> D_OE=0 on the next edge.
  - Without the macro -> D_OE stays 0.
